icache_fill_controller: RTL and testbench

- Sequences the single-line instruction cache that sits between the program ROM and the instruction decoder.
- Checks each fetch for a hit or miss against the line tag.
- On a miss, holds the core (`hold_out`), walks the ROM through one full line and drives the cache write port word by word. It then marks the line valid and releases the hold.
- Takes over all line-fill sequencing from the program sequencer. The sequencer only supplies the requested address.

---
 rtl/icache_pkg.sv | 22 ++
 rtl/icache_fill_controller_fill_counter.sv | 62 ++++++
 rtl/icache_fill_controller.sv | 102 ++++++++++
 tb/tb_icache_fill_controller.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and default geometry for the single-line instruction cache fill path.
// Geometry defaults here are what the top and the counter use unless overridden.
package icache_pkg;

  localparam int ADDR_W_DEF      = 8;
  localparam int OFFSET_W_DEF    = 5;
  localparam int LINE_WORDS_DEF  = 1 << OFFSET_W_DEF;
  localparam int TAG_W_DEF       = ADDR_W_DEF - OFFSET_W_DEF;
  localparam int ROM_LATENCY_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    RESUME = 2'd2
  } state_t;

  // Width of a counter that must reach lat-1; never narrower than one bit.
  function automatic int lat_width(input int lat);
    return (lat <= 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/icache_fill_controller_fill_counter.sv
// Latency/word counter pair for one line fill. wr_strobe is a register that is high
// exactly on the cycles where the latency counter sits at ROM_LATENCY-1.
module fill_counter
  import icache_pkg::*;
#(
  parameter int OFFSET_W    = OFFSET_W_DEF,
  parameter int ROM_LATENCY = ROM_LATENCY_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                advance,
  output logic [OFFSET_W-1:0] word_ctr,
  output logic                wr_strobe,
  output logic                last_word
);

  localparam int LAT_W = lat_width(ROM_LATENCY);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ROM_LATENCY - 1);

  logic [LAT_W-1:0]    lat_ctr;
  logic [LAT_W-1:0]    lat_nxt;
  logic [OFFSET_W-1:0] word_nxt;
  logic                strobe_nxt;
  logic                done;

  assign last_word = &word_ctr;

  // The strobe is computed one cycle ahead so cache_wren leaves a flop yet lines
  // up with the cycle on which the latency counter reaches its last value.
  always_comb begin
    lat_nxt    = '0;
    word_nxt   = '0;
    strobe_nxt = 1'b0;
    done       = wr_strobe & last_word;
    if (start) begin
      strobe_nxt = (LAT_LAST == '0);
    end else if (advance && !done) begin
      if (wr_strobe) begin
        lat_nxt  = '0;
        word_nxt = word_ctr + 1'b1;
      end else begin
        lat_nxt  = lat_ctr + 1'b1;
        word_nxt = word_ctr;
      end
      strobe_nxt = (lat_nxt == LAT_LAST);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_ctr   <= '0;
      word_ctr  <= '0;
      wr_strobe <= 1'b0;
    end else begin
      lat_ctr   <= lat_nxt;
      word_ctr  <= word_nxt;
      wr_strobe <= strobe_nxt;
    end
  end

endmodule

// File: rtl/icache_fill_controller.sv
// Hit/miss check and line-fill sequencer for a single-line instruction cache.
// Valid/ready is not used: a miss raises hold_out and the core waits until it drops.
module icache_fill_controller
  import icache_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int OFFSET_W    = OFFSET_W_DEF,
  parameter int ROM_LATENCY = ROM_LATENCY_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          pm_addr_req,
  input  logic                       fetch_valid,
  input  logic                       flush,
  output logic [ADDR_W-1:0]          rom_address,
  output logic [OFFSET_W-1:0]        cache_wroffset,
  output logic                       cache_wren,
  output logic [OFFSET_W-1:0]        cache_rdoffset,
  output logic                       hold_out,
  output logic                       hit,
  output logic                       line_valid,
  output logic [ADDR_W-OFFSET_W-1:0] line_tag,
  output logic [7:0]                 miss_count,
  output logic [1:0]                 fsm_state
);

  localparam int TAG_W = ADDR_W - OFFSET_W;

  state_t              state;
  logic [TAG_W-1:0]    req_tag;
  logic [TAG_W-1:0]    fetch_tag;
  logic                flush_pend;
  logic                miss;
  logic [OFFSET_W-1:0] word_ctr;
  logic [OFFSET_W-1:0] word_inc;
  logic                wr_strobe;
  logic                last_word;

  assign fetch_tag      = pm_addr_req[ADDR_W-1:OFFSET_W];
  assign cache_rdoffset = pm_addr_req[OFFSET_W-1:0];
  assign hit            = (state == IDLE) & fetch_valid & line_valid & (fetch_tag == line_tag);
  assign miss           = (state == IDLE) & fetch_valid & ~hit;
  assign hold_out       = (state != IDLE) | miss;
  assign word_inc       = word_ctr + 1'b1;
  assign cache_wren     = wr_strobe;
  assign cache_wroffset = word_ctr;
  assign fsm_state      = state;

  fill_counter #(
    .OFFSET_W   (OFFSET_W),
    .ROM_LATENCY(ROM_LATENCY)
  ) u_fill_counter (
    .clk      (clk),
    .reset    (reset),
    .start    (miss),
    .advance  (state == FILL),
    .word_ctr (word_ctr),
    .wr_strobe(wr_strobe),
    .last_word(last_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      req_tag     <= '0;
      line_valid  <= 1'b0;
      line_tag    <= '0;
      miss_count  <= '0;
      flush_pend  <= 1'b0;
      rom_address <= '0;
    end else begin
      case (state)
        IDLE: begin
          rom_address <= {fetch_tag, {OFFSET_W{1'b0}}};
          if (flush) line_valid <= 1'b0;
          if (miss) begin
            req_tag <= fetch_tag;
            if (miss_count != 8'hFF) miss_count <= miss_count + 8'd1;
            state <= FILL;
          end
        end
        FILL: begin
          if (flush) flush_pend <= 1'b1;
          // Advance the ROM address right after each word is written.
          if (wr_strobe) begin
            rom_address <= {req_tag, word_inc};
            if (last_word) state <= RESUME;
          end
        end
        RESUME: begin
          line_tag    <= req_tag;
          line_valid  <= ~(flush_pend | flush);
          flush_pend  <= 1'b0;
          rom_address <= {fetch_tag, {OFFSET_W{1'b0}}};
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_fill_controller.sv
// Directed and randomized fetches against a line-level model of the cache:
// a valid bit, a resident tag and a saturating miss count.
module tb_icache_fill_controller;

  localparam int AW  = 8;
  localparam int OW  = 5;
  localparam int LW  = 1 << OW;
  localparam int LAT = 2;
  localparam int FL  = LW * LAT;

  logic          clk;
  logic          reset;
  logic [AW-1:0] pm_addr_req;
  logic          fetch_valid;
  logic          flush;
  logic [AW-1:0] rom_address;
  logic [OW-1:0] cache_wroffset;
  logic          cache_wren;
  logic [OW-1:0] cache_rdoffset;
  logic          hold_out;
  logic          hit;
  logic          line_valid;
  logic [AW-OW-1:0] line_tag;
  logic [7:0]    miss_count;
  logic [1:0]    fsm_state;

  int n_vec = 0;
  int n_err = 0;

  bit m_valid = 0;
  int m_tag   = 0;
  int m_miss  = 0;

  icache_fill_controller #(
    .ADDR_W(AW), .OFFSET_W(OW), .ROM_LATENCY(LAT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pm_addr_req   (pm_addr_req),
    .fetch_valid   (fetch_valid),
    .flush         (flush),
    .rom_address   (rom_address),
    .cache_wroffset(cache_wroffset),
    .cache_wren    (cache_wren),
    .cache_rdoffset(cache_rdoffset),
    .hold_out      (hold_out),
    .hit           (hit),
    .line_valid    (line_valid),
    .line_tag      (line_tag),
    .miss_count    (miss_count),
    .fsm_state     (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic chk_reset_values();
    chk("rst_rom", rom_address, 0);
    chk("rst_wren", cache_wren, 0);
    chk("rst_wroff", cache_wroffset, 0);
    chk("rst_hold", hold_out, 0);
    chk("rst_hit", hit, 0);
    chk("rst_valid", line_valid, 0);
    chk("rst_tag", line_tag, 0);
    chk("rst_miss", miss_count, 0);
    chk("rst_state", fsm_state, 0);
  endtask

  // flush_k: -1 none, 0 with the fetch, k>0 on hold cycle k. reset_k>0 aborts on hold cycle k.
  task automatic fetch(input logic [AW-1:0] addr, input int flush_k, input int reset_k);
    int   tag;
    logic exp_hit;
    bit   flushed;
    tag = int'(addr[AW-1:OW]);
    @(negedge clk);
    pm_addr_req = addr;
    fetch_valid = 1'b1;
    flush       = (flush_k == 0);
    #1;
    exp_hit = m_valid && (m_tag == tag);
    chk("hit", hit, exp_hit);
    chk("hold", hold_out, !exp_hit);
    chk("rdoffset", cache_rdoffset, addr[OW-1:0]);
    if (flush_k == 0) m_valid = 0;
    if (exp_hit) begin
      @(negedge clk);
      fetch_valid = 1'b0;
      flush       = 1'b0;
      chk("wren_on_hit", cache_wren, 0);
      chk("valid_after_hit", line_valid, m_valid);
      return;
    end
    if (m_miss < 255) m_miss++;
    flushed = 0;
    for (int k = 1; k <= FL + 1; k++) begin
      @(negedge clk);
      flush = 1'b0;
      if (k == reset_k) begin
        reset       = 1'b0;
        fetch_valid = 1'b0;
        #1;
        chk_reset_values();
        m_valid = 0;
        m_tag   = 0;
        m_miss  = 0;
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      chk("fill_hold", hold_out, 1);
      chk("fill_hit", hit, 0);
      chk("fill_misscnt", miss_count, m_miss);
      if (k <= FL) begin
        chk("fill_state", fsm_state, 1);
        chk("fill_rom", rom_address, (tag << OW) | ((k - 1) / LAT));
        chk("fill_wren", cache_wren, (k % LAT) == 0);
        if ((k % LAT) == 0) chk("fill_wroff", cache_wroffset, (k / LAT) - 1);
      end else begin
        chk("resume_state", fsm_state, 2);
        chk("resume_wren", cache_wren, 0);
      end
      if (k == flush_k) begin
        flush   = 1'b1;
        flushed = 1;
      end
    end
    @(negedge clk);
    flush   = 1'b0;
    m_tag   = tag;
    m_valid = !flushed;
    #1;
    chk("post_hit", hit, m_valid);
    chk("post_hold", hold_out, !m_valid);
    chk("post_valid", line_valid, m_valid);
    chk("post_tag", line_tag, m_tag);
    chk("post_misscnt", miss_count, m_miss);
    fetch_valid = 1'b0;
  endtask

  task automatic idle(input bit do_flush);
    @(negedge clk);
    fetch_valid = 1'b0;
    flush       = do_flush;
    pm_addr_req = AW'($urandom);
    #1;
    chk("idle_hit", hit, 0);
    chk("idle_hold", hold_out, 0);
    @(negedge clk);
    flush = 1'b0;
    if (do_flush) m_valid = 0;
    chk("idle_valid", line_valid, m_valid);
    chk("idle_wren", cache_wren, 0);
  endtask

  initial begin
    reset       = 1'b0;
    pm_addr_req = '0;
    fetch_valid = 1'b0;
    flush       = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_values();
    reset = 1'b1;

    fetch(8'h00, -1, 0);
    fetch(8'h05, -1, 0);
    fetch(8'h25, -1, 0);
    fetch(8'h45, 21, 0);
    fetch(8'h45, -1, 0);
    fetch(8'h60, -1, 31);
    fetch(8'h60, -1, 0);
    fetch(8'h61, 0, 0);
    fetch(8'h61, -1, 0);
    fetch(8'h80, FL + 1, 0);
    fetch(8'h80, -1, 0);
    idle(1'b1);
    fetch(8'h9F, -1, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1'($urandom_range(0, 1)));
      end else begin
        fetch(AW'($urandom_range(0, 95)),
              ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, FL + 1)) : -1, 0);
      end
    end

    for (int i = 0; i < 260; i++) begin
      fetch(AW'((((m_tag + 1) % 8) << OW) | $urandom_range(0, LW - 1)), -1, 0);
      idle(1'b1);
    end
    chk("miss_saturated", miss_count, 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
